fifo_drain_packer: RTL and testbench

Downstream consumer of the byte FIFO. It pops bytes whenever the FIFO is non-empty and packs LANES consecutive bytes into one wide word. The word is presented on a valid/ready output port with one word of output buffering, so packing continues while the sink stalls. Partial words are emitted on an explicit flush, or on an idle timeout when that feature is compiled in.

---
 rtl/fifo_pack_pkg.sv | 18 +
 rtl/fifo_idle_timer.sv | 47 ++++
 rtl/fifo_drain_packer.sv | 154 +++++++++++++++
 tb/tb_fifo_drain_packer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types, default sizes and the lane keep-mask helper for the FIFO drain packer.
package fifo_pack_pkg;

  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned LANES_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } pack_state_e;

  // Mask with the low cnt bits set; callers truncate to their lane count.
  function automatic logic [31:0] keep_of(input logic [5:0] cnt);
    keep_of = (32'd1 << cnt) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle counter for the packer: emits a one-cycle pulse when TIMEOUT idle cycles accumulate.
module fifo_idle_timer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic fire
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] count_q, count_d;
  logic          fire_q, fire_d;

  // Saturating idle count; the pulse marks the cycle the limit is first reached.
  always_comb begin
    count_d = count_q;
    fire_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + TW'(1);
    end else begin
      count_d = count_q;
    end
    fire_d = (count_d == LIMIT) && (count_q != LIMIT);
  end

  // Counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      count_q <= '0;
      fire_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      fire_q  <= fire_d;
    end
  end

  assign fire = fire_q;

endmodule

// File: rtl/fifo_drain_packer.sv
// Pops bytes from the byte FIFO and packs LANES of them into one word behind a valid/ready port.
// Optional idle-timeout flush is enabled by defining PACKER_TIMEOUT_FLUSH_EN.
module fifo_drain_packer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DW-1:0]         fifo_dataout,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic                  flush,
  output logic [DW*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CW  = $clog2(LANES + 1);
  localparam int unsigned LIW = $clog2(LANES);
  localparam logic [CW-1:0] LANES_CNT = CW'(LANES);
  localparam logic [CW:0]   LANES_SUM = (CW + 1)'(LANES);

  logic [LANES-1:0][DW-1:0] pack_q, pack_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_cap_s;
  logic                     rd_pend_q, rd_pend_d;
  logic [DW*LANES-1:0]      out_data_q, out_data_d;
  logic [LANES-1:0]         out_keep_q, out_keep_d;
  logic                     out_valid_q, out_valid_d;
  pack_state_e              state_q, state_d;

  logic                     ofree_s;
  logic                     flush_pend_s;
  logic                     timeout_s;
  logic                     emit_s;
  logic [CW:0]              inflight_s;
  logic [LANES-1:0]         keep_part_s;

  assign ofree_s      = !out_valid_q || out_ready;
  assign flush_pend_s = (state_q == S_FLUSH);
  assign inflight_s   = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};

  // A read may start on a full-with-in-flight word only if that word can leave this cycle.
  assign fifo_read = !fifo_empty && !flush_pend_s &&
                     ((inflight_s < LANES_SUM) ||
                      ((inflight_s == LANES_SUM) && rd_pend_q && ofree_s));
  assign rd_pend_d = fifo_read;

  // Capture, word emission and flush sequencing.
  always_comb begin
    pack_d      = pack_q;
    cnt_cap_s   = cnt_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    emit_s      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (rd_pend_q && (cnt_q < LANES_CNT)) begin
      pack_d[cnt_q[LIW-1:0]] = fifo_dataout;
      cnt_cap_s              = cnt_q + CW'(1);
    end else begin
      cnt_cap_s = cnt_q;
    end

    keep_part_s = LANES'(keep_of(6'(cnt_cap_s)));

    // Reads are blocked in S_FLUSH, so the byte captured here is the last one owed to the partial word.
    if (ofree_s && ((cnt_cap_s == LANES_CNT) || (flush_pend_s && (cnt_cap_s != '0)))) begin
      emit_s      = 1'b1;
      out_data_d  = pack_d;
      out_keep_d  = keep_part_s;
      out_valid_d = 1'b1;
      pack_d      = '0;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_cap_s;
    end

    case (state_q)
      S_FILL: begin
        if (flush || timeout_s) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FLUSH: begin
        if ((cnt_cap_s == '0) || emit_s) begin
          state_d = S_FILL;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

`ifdef PACKER_TIMEOUT_FLUSH_EN
  logic idle_inc_s;
  logic idle_clr_s;

  assign idle_inc_s = (cnt_q != '0) && !rd_pend_q && fifo_empty;
  assign idle_clr_s = rd_pend_q || emit_s;

  fifo_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk  (clk),
    .rstn (rstn),
    .inc  (idle_inc_s),
    .clr  (idle_clr_s),
    .fire (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // State registers; reset drops the pack contents, the in-flight byte and any pending word.
  always_ff @(posedge clk) begin
    if (rstn) begin
      pack_q      <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      state_q     <= S_FILL;
    end else begin
      pack_q      <= pack_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Self-checking bench for fifo_drain_packer: table of flush cases, directed corner sequences,
// and a randomized stream checked against a byte-grouping reference model.
module tb_fifo_drain_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  fifo_dataout = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_read;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_drain_packer dut (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_dataout (fifo_dataout),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .flush        (flush),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  logic [7:0]  fq[$];
  logic [7:0]  stage[$];
  logic [35:0] got[$];
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int rd_count = 0;
  int first_rd = -1;
  int last_rd = -1;
  int first_vld = -1;
  logic        prev_stall = 1'b0;
  logic [35:0] prev_word = 36'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte FIFO model: one-cycle read latency, staged pushes become visible after the next edge.
  always @(posedge clk) begin
    logic [7:0] b;
    cyc <= cyc + 1;
    if (rstn) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read) begin
        if (fq.size() > 0) begin
          b = fq.pop_front();
          fifo_dataout <= b;
        end
      end
      while (stage.size() > 0) fq.push_back(stage.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Output monitor: collects handshaken words and checks stability under back-pressure.
  always @(negedge clk) begin
    if (!rstn) begin
      if (fifo_read) begin
        rd_count++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall) chk("hold", {out_valid, out_keep, out_data}, {1'b1, prev_word});
      if (out_valid && out_ready) got.push_back({out_keep, out_data});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_keep, out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    got.delete();
    rd_count = 0;
    first_rd = -1;
    last_rd = -1;
    first_vld = -1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    flush = 1'b0;
    step(2);
    rstn = 1'b0;
    clr_mon();
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) stage.push_back(8'(base + i));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  typedef struct {
    int          nb;
    logic [7:0]  base;
    int          nw;
    logic [35:0] w0;
    logic [35:0] w1;
  } vec_t;

  vec_t tbl[7];
  logic [7:0] model[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int f;
    int nexp;
    int idle;
    logic [7:0] b;
    logic [35:0] w;
    logic found;

    tbl[0] = '{3, 8'hA1, 1, {4'b0111, 32'h00A3A2A1}, 36'h0};
    tbl[1] = '{1, 8'h5C, 1, {4'b0001, 32'h0000005C}, 36'h0};
    tbl[2] = '{2, 8'h55, 1, {4'b0011, 32'h00005655}, 36'h0};
    tbl[3] = '{4, 8'h31, 1, {4'b1111, 32'h34333231}, 36'h0};
    tbl[4] = '{6, 8'h41, 2, {4'b1111, 32'h44434241}, {4'b0011, 32'h00004645}};
    tbl[5] = '{0, 8'h00, 0, 36'h0, 36'h0};
    tbl[6] = '{8, 8'h11, 2, {4'b1111, 32'h14131211}, {4'b1111, 32'h18171615}};

    // Reset state
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_keep", out_keep, 4'h0);
    chk("rst_read", fifo_read, 1'b0);

    // Table: n bytes, idle, flush, then a second flush that must emit nothing
    for (int i = 0; i < 7; i++) begin
      do_reset();
      out_ready = 1'b1;
      push_bytes(tbl[i].base, tbl[i].nb);
      step(12);
      first_vld = -1;
      f = cyc;
      pulse_flush();
      step(10);
      chk($sformatf("tbl%0d_nwords", i), got.size(), tbl[i].nw);
      if (tbl[i].nw >= 1 && got.size() >= 1) chk($sformatf("tbl%0d_w0", i), got[0], tbl[i].w0);
      if (tbl[i].nw >= 2 && got.size() >= 2) chk($sformatf("tbl%0d_w1", i), got[1], tbl[i].w1);
      if (tbl[i].nb % 4 != 0) chk($sformatf("tbl%0d_flush_lat", i), (first_vld >= 0) && (first_vld - f <= 2), 1'b1);
      got.delete();
      pulse_flush();
      step(6);
      chk($sformatf("tbl%0d_reflush", i), got.size(), 0);
    end

    // Latency and back-to-back throughput
    do_reset();
    out_ready = 1'b1;
    push_bytes(8'h11, 8);
    step(20);
    chk("lat_reads", rd_count, 8);
    chk("lat_consec", last_rd - first_rd + 1, 8);
    chk("lat_first_valid", first_vld - first_rd, 5);
    chk("lat_nwords", got.size(), 2);
    if (got.size() >= 2) begin
      chk("lat_w0", got[0], {4'hF, 32'h14131211});
      chk("lat_w1", got[1], {4'hF, 32'h18171615});
    end

    // Sink stall: reads stop after two words' worth, then drain in order
    do_reset();
    out_ready = 1'b0;
    push_bytes(8'h11, 12);
    step(25);
    chk("stall_reads", rd_count, 8);
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_data", out_data, 32'h14131211);
    chk("stall_none_taken", got.size(), 0);
    out_ready = 1'b1;
    step(20);
    chk("stall_nwords", got.size(), 3);
    if (got.size() >= 3) begin
      chk("stall_w0", got[0], {4'hF, 32'h14131211});
      chk("stall_w1", got[1], {4'hF, 32'h18171615});
      chk("stall_w2", got[2], {4'hF, 32'h1C1B1A19});
    end

    // Reset while a word is pending and two bytes are packed
    do_reset();
    out_ready = 1'b0;
    push_bytes(8'h61, 6);
    step(15);
    chk("midrst_pre_valid", out_valid, 1'b1);
    rstn = 1'b1;
    step(1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_read", fifo_read, 1'b0);
    rstn = 1'b0;
    clr_mon();
    out_ready = 1'b1;
    push_bytes(8'hC1, 4);
    step(15);
    chk("midrst_nwords", got.size(), 1);
    if (got.size() >= 1) chk("midrst_w0", got[0], {4'hF, 32'hC4C3C2C1});

    // Flush coincident with the fourth capture
    do_reset();
    out_ready = 1'b1;
    push_bytes(8'h71, 4);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (fifo_read) found = 1'b1;
    end
    chk("coinc_read_seen", found, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    pulse_flush();
    step(10);
    chk("coinc_nwords", got.size(), 1);
    if (got.size() >= 1) chk("coinc_w0", got[0], {4'hF, 32'h74737271});

    // Idle behaviour with a partial word and an empty FIFO
    do_reset();
    out_ready = 1'b1;
    push_bytes(8'h55, 1);
    push_bytes(8'h66, 1);
    step(100);
`ifdef PACKER_TIMEOUT_FLUSH_EN
    chk("tmo_nwords", got.size(), 1);
    if (got.size() >= 1) chk("tmo_w0", got[0], {4'b0011, 32'h00006655});
    chk("tmo_not_early", (first_vld >= 0) && (first_vld - last_rd >= 16), 1'b1);
`else
    chk("notmo_nwords", got.size(), 0);
    chk("notmo_no_valid", first_vld, -1);
`endif

    // Randomized stream against the grouping model
    do_reset();
    model.delete();
    idle = 0;
    for (int k = 0; k < 800; k++) begin
      if (($urandom % 4 != 0) || idle >= 8) begin
        b = 8'($urandom);
        stage.push_back(b);
        model.push_back(b);
        idle = 0;
      end else begin
        idle++;
      end
      out_ready = 1'($urandom % 2);
      step(1);
    end
    while (model.size() % 4 != 0) begin
      b = 8'($urandom);
      stage.push_back(b);
      model.push_back(b);
    end
    out_ready = 1'b1;
    nexp = model.size() / 4;
    for (int k = 0; k < 3000 && got.size() < nexp; k++) step(1);
    step(5);
    chk("rand_nwords", got.size(), nexp);
    for (int j = 0; j < nexp && j < got.size(); j++) begin
      w = {4'hF, model[4*j+3], model[4*j+2], model[4*j+1], model[4*j]};
      chk($sformatf("rand_w%0d", j), got[j], w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
